// File: rtl/bit_register_display.sv
// bit_register_display: bit-addressable register with a time-multiplexed
// 7-segment readout (binary: one bit per digit, hex: one nibble per digit).
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit; digit 0 always stays lit.
module bit_register_display #(
  parameter int WIDTH       = 8,
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = $clog2(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [1:0]            op,
  input  logic [IDX_W-1:0]      bit_index,
  input  logic                  bit_value,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  hex_mode,
  output logic [WIDTH-1:0]      reg_q,
  output logic [7:0]            Seg,
  output logic [NUM_DIGITS-1:0] Anodes,
  output logic                  idx_err
);

  localparam int PRE_W      = $clog2(REFRESH_DIV);
  localparam int PTR_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PAD_W      = WIDTH + 4 * NUM_DIGITS;
  localparam int HEX_DIGITS = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] op_result;
  logic             index_bad;

  logic [PRE_W-1:0] prescaler;
  logic [PTR_W-1:0] ptr;
  logic             wrap;
  logic [PAD_W-1:0] padded;
  logic [3:0]       nibble;
  logic             bit_val;
  logic             blank;
  logic [7:0]       glyph;
  logic [7:0]       seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic [PTR_W-1:0] top_digit;
`endif

  // Standard active-low 0-F glyphs, {A,B,C,D,E,F,G,DP}, DP off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'b0000_0011;
      4'h1: g = 8'b1001_1111;
      4'h2: g = 8'b0010_0101;
      4'h3: g = 8'b0000_1101;
      4'h4: g = 8'b1001_1001;
      4'h5: g = 8'b0100_1001;
      4'h6: g = 8'b0100_0001;
      4'h7: g = 8'b0001_1111;
      4'h8: g = 8'b0000_0001;
      4'h9: g = 8'b0000_1001;
      4'hA: g = 8'b0001_0001;
      4'hB: g = 8'b1100_0001;
      4'hC: g = 8'b0110_0011;
      4'hD: g = 8'b1000_0101;
      4'hE: g = 8'b0110_0001;
      default: g = 8'b0111_0001;
    endcase
    return g;
  endfunction

  // Result of the requested bit operation applied to the current word.
  always_comb begin
    bit_mask  = WIDTH'(1) << bit_index;
    index_bad = 32'(bit_index) >= WIDTH;
    op_result = reg_q;
    case (op)
      2'b00: op_result = bit_value ? (reg_q | bit_mask) : (reg_q & ~bit_mask);
      2'b01: op_result = reg_q | bit_mask;
      2'b10: op_result = reg_q & ~bit_mask;
      default: op_result = reg_q ^ bit_mask;
    endcase
  end

  // Register and sticky error flag; a whole-word load beats any bit op.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      reg_q   <= '0;
      idx_err <= 1'b0;
    end else if (load) begin
      reg_q   <= load_data;
      idx_err <= 1'b0;
    end else if (valid_in) begin
      if (index_bad) begin
        idx_err <= 1'b1;
      end else begin
        reg_q <= op_result;
      end
    end
  end

  // Glyph for the digit being strobed next, sampled from the live register.
  always_comb begin
    wrap    = prescaler == PRE_W'(REFRESH_DIV - 1);
    padded  = PAD_W'(reg_q);
    nibble  = padded[4*ptr +: 4];
    bit_val = padded[ptr];
    blank   = hex_mode ? (32'(ptr) >= HEX_DIGITS) : (32'(ptr) >= WIDTH);
    glyph   = hex_mode ? hex_glyph(nibble)
                       : (bit_val ? 8'b1001_1111 : 8'b0000_0011);
`ifdef LEADING_ZERO_BLANK_EN
    top_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hex_mode ? (padded[4*i +: 4] != 4'h0) : padded[i]) begin
        top_digit = PTR_W'(i);
      end
    end
    if (ptr > top_digit) begin
      blank = 1'b1;
    end
`endif
    seg_next = blank ? 8'hFF : glyph;
  end

  // Scan timing: the pointer names the digit lit at the next prescaler wrap,
  // so the first wrap after reset lights digit 0 and then moves on.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      ptr       <= '0;
      Seg       <= 8'hFF;
      Anodes    <= '1;
    end else if (wrap) begin
      prescaler <= '0;
      Seg       <= seg_next;
      Anodes    <= ~(NUM_DIGITS'(1) << ptr);
      ptr       <= (ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_register_display.sv
// tb_bit_register_display: randomized and directed checks of
// bit_register_display against a word-level reference model.
module tb_bit_register_display;

  localparam int RD = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;

  logic       valid_in = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] bit_index = 3'd0;
  logic       bit_value = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       hex_mode = 1'b0;
  logic [7:0] reg_q;
  logic [7:0] Seg;
  logic [7:0] Anodes;
  logic       idx_err;

  logic       valid_in_n = 1'b0;
  logic [1:0] op_n = 2'b00;
  logic [2:0] bit_index_n = 3'd0;
  logic       bit_value_n = 1'b0;
  logic       load_n = 1'b0;
  logic [5:0] load_data_n = 6'h00;
  logic [5:0] reg_q_n;
  logic [7:0] Seg_n;
  logic [7:0] Anodes_n;
  logic       idx_err_n;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] model_q = 0;
  bit          model_err = 0;
  logic [31:0] model_q_n = 0;
  bit          model_err_n = 0;

  logic [7:0] glyphs [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  bit_register_display #(.WIDTH(8), .NUM_DIGITS(8), .REFRESH_DIV(RD)) dut (
    .CLK(CLK), .rst(rst), .valid_in(valid_in), .op(op), .bit_index(bit_index),
    .bit_value(bit_value), .load(load), .load_data(load_data), .hex_mode(hex_mode),
    .reg_q(reg_q), .Seg(Seg), .Anodes(Anodes), .idx_err(idx_err)
  );

  bit_register_display #(.WIDTH(6), .NUM_DIGITS(8), .REFRESH_DIV(RD)) dut_narrow (
    .CLK(CLK), .rst(rst), .valid_in(valid_in_n), .op(op_n), .bit_index(bit_index_n),
    .bit_value(bit_value_n), .load(load_n), .load_data(load_data_n), .hex_mode(1'b0),
    .reg_q(reg_q_n), .Seg(Seg_n), .Anodes(Anodes_n), .idx_err(idx_err_n)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference register behaviour, returns {err, word}.
  function automatic logic [32:0] model_next(input logic [31:0] q, input bit err,
      input bit v, input int o, input int idx, input bit bv, input bit ld,
      input logic [31:0] ldd, input int width);
    logic [31:0] m;
    m = 32'(1) << idx;
    if (ld) return {1'b0, ldd & ((32'(1) << width) - 1)};
    if (!v) return {err, q};
    if (idx >= width) return {1'b1, q};
    case (o)
      0: q = bv ? (q | m) : (q & ~m);
      1: q = q | m;
      2: q = q & ~m;
      default: q = q ^ m;
    endcase
    return {err, q};
  endfunction

  // Expected glyph of digit d for an 8-bit register value.
  function automatic logic [7:0] exp_seg(input int d, input logic [31:0] value, input bit hexm);
    int k, ndig;
    logic [31:0] rest;
    k    = hexm ? 4 : 1;
    ndig = hexm ? 2 : 8;
    if (d >= ndig) return 8'hFF;
    rest = value >> (k * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && rest == 0) return 8'hFF;
`endif
    if (hexm) return glyphs[rest[3:0]];
    return rest[0] ? 8'h9F : 8'h03;
  endfunction

  // One cycle on the wide DUT: drive, clock, then compare with the model.
  task automatic applyStimulus(input bit v, input logic [1:0] o, input logic [2:0] idx,
                               input bit bv, input bit ld, input logic [7:0] ldd);
    logic [32:0] nx;
    valid_in = v; op = o; bit_index = idx; bit_value = bv; load = ld; load_data = ldd;
    @(negedge CLK);
    nx = model_next(model_q, model_err, v, int'(o), int'(idx), bv, ld, 32'(ldd), 8);
    model_q = nx[31:0]; model_err = nx[32];
    checkOutput("reg_q", 32'(reg_q), model_q);
    checkOutput("idx_err", 32'(idx_err), 32'(model_err));
    valid_in = 1'b0; load = 1'b0;
  endtask

  // Narrow DUT update after a clock edge already taken by applyStimulus.
  task automatic checkNarrow();
    logic [32:0] nx;
    nx = model_next(model_q_n, model_err_n, valid_in_n, int'(op_n), int'(bit_index_n),
                    bit_value_n, load_n, 32'(load_data_n), 6);
    model_q_n = nx[31:0]; model_err_n = nx[32];
    checkOutput("narrow_reg_q", 32'(reg_q_n), model_q_n);
    checkOutput("narrow_idx_err", 32'(idx_err_n), 32'(model_err_n));
    valid_in_n = 1'b0; load_n = 1'b0;
  endtask

  // Let the display catch up, then follow one full scan of all digits.
  task automatic checkScan(input bit hexm);
    logic [7:0] target;
    int n;
    hex_mode = hexm;
    repeat (RD + 1) @(negedge CLK);
    for (int d = 0; d < 8; d++) begin
      target = ~(8'd1 << d);
      n = 0;
      while (Anodes !== target && n < 40) begin
        @(negedge CLK);
        n++;
      end
      checkOutput($sformatf("anodes_d%0d", d), 32'(Anodes), 32'(target));
      checkOutput($sformatf("seg_d%0d_h%0d", d, hexm), 32'(Seg), 32'(exp_seg(d, model_q, hexm)));
    end
  endtask

  // After reset release the display stays dark until digit 0 lights at cycle RD.
  task automatic checkStartup();
    for (int k = 1; k <= RD; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("startup_anodes_c%0d", k), 32'(Anodes), (k == RD) ? 32'hFE : 32'hFF);
    end
    checkOutput("startup_seg", 32'(Seg), 32'(exp_seg(0, model_q, hex_mode)));
  endtask

  initial begin
    logic [1:0] ro;
    logic [2:0] ri;
    logic [7:0] rd;
    $display("[TB] start");
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    checkStartup();

    // Run mid-scan, then assert reset away from any clock edge.
    applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 8'h3C);
    repeat (7) @(negedge CLK);
    #2 rst = 1'b0;
    #1;
    model_q = 0; model_err = 0; model_q_n = 0; model_err_n = 0;
    checkOutput("rst_seg", 32'(Seg), 32'hFF);
    checkOutput("rst_anodes", 32'(Anodes), 32'hFF);
    checkOutput("rst_reg_q", 32'(reg_q), 32'h0);
    checkOutput("rst_idx_err", 32'(idx_err), 32'h0);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    checkStartup();

    // Single write of bit 7, then bit-op sequence.
    applyStimulus(1'b1, 2'b00, 3'd7, 1'b1, 1'b0, 8'h00);
    checkOutput("write_b7", 32'(reg_q), 32'h80);
    checkScan(1'b0);
    applyStimulus(1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 8'h00);
    checkOutput("set_b1", 32'(reg_q), 32'h82);
    applyStimulus(1'b1, 2'b11, 3'd1, 1'b0, 1'b0, 8'h00);
    checkOutput("tog_b1_a", 32'(reg_q), 32'h80);
    applyStimulus(1'b1, 2'b11, 3'd1, 1'b0, 1'b0, 8'h00);
    checkOutput("tog_b1_b", 32'(reg_q), 32'h82);
    applyStimulus(1'b1, 2'b10, 3'd7, 1'b0, 1'b0, 8'h00);
    checkOutput("clr_b7", 32'(reg_q), 32'h02);

    // Load wins over a simultaneous bit op.
    applyStimulus(1'b1, 2'b01, 3'd0, 1'b0, 1'b1, 8'hA5);
    checkOutput("load_priority", 32'(reg_q), 32'hA5);
    checkScan(1'b1);
    checkScan(1'b0);

    // Out-of-range index on the 6-bit instance: sticky until a load.
    valid_in_n = 1'b1; op_n = 2'b01; bit_index_n = 3'd7;
    applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00);
    checkNarrow();
    checkOutput("narrow_err_set", 32'(idx_err_n), 32'h1);
    repeat (3) applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00);
    checkOutput("narrow_err_held", 32'(idx_err_n), 32'h1);
    load_n = 1'b1; load_data_n = 6'h2A;
    applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 8'h00);
    checkNarrow();
    checkOutput("narrow_err_clr", 32'(idx_err_n), 32'h0);

    // Leading-zero cases and an all-zero register.
    applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 8'h05);
    checkScan(1'b0);
    applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 8'h00);
    checkScan(1'b0);
    checkScan(1'b1);

    // Randomized traffic on both instances, every cycle compared.
    for (int t = 0; t < 300; t++) begin
      ro = 2'($urandom_range(0, 3));
      ri = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      valid_in_n  = 1'($urandom_range(0, 1));
      op_n        = 2'($urandom_range(0, 3));
      bit_index_n = 3'($urandom_range(0, 7));
      bit_value_n = 1'($urandom_range(0, 1));
      load_n      = ($urandom_range(0, 9) == 0);
      load_data_n = 6'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), ro, ri, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0, rd);
      checkNarrow();
    end
    checkScan(1'b1);
    checkScan(1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
